// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter phase monitor.
package ring_pkg;

  localparam int unsigned RING_W = 4;

  localparam logic [RING_W-1:0] HOME_ROT_RIGHT = 4'b1000;
  localparam logic [RING_W-1:0] HOME_ROT_LEFT  = 4'b0001;

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    LOCKED,
    FAULT
  } ring_state_e;

  // Expected next phase of the ring for the given rotation direction.
  function automatic logic [RING_W-1:0] ring_succ(input logic [RING_W-1:0] phase,
                                                  input logic              rot_left);
    return rot_left ? {phase[RING_W-2:0], phase[RING_W-1]}
                    : {phase[0], phase[RING_W-1:1]};
  endfunction

endpackage

// File: rtl/onehot_enc4.sv
// 4-bit one-hot to binary index encoder; valid only for exactly one set bit.
module onehot_enc4 (
  input  logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b1;
    unique case (onehot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter for legal rotation, locks onto it,
// counts revolutions and exposes the current phase as a binary index.
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 4,
  parameter int unsigned REV_W       = 8,
  parameter bit          ROT_LEFT    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        phase_i,
  input  logic              clr_i,
  output logic              locked_o,
  output logic              err_o,
  output logic              err_sticky_o,
  output logic [REV_W-1:0]  rev_cnt_o,
  output logic              rev_tick_o,
  output logic [1:0]        idx_o,
  output logic              idx_valid_o
);

  localparam int unsigned RUN_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CYCLES - 1);
  localparam logic [RING_W-1:0] HOME = ROT_LEFT ? HOME_ROT_LEFT : HOME_ROT_RIGHT;

  logic [RING_W-1:0] ph_q;
  logic [RING_W-1:0] ph_prev;
  ring_state_e       state;
  logic [RUN_W-1:0]  run;

  logic [1:0] enc_idx;
  logic       onehot;
  logic       legal;
  logic       home;
  logic       rev_inc;
  logic       lose_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q    <= '0;
      ph_prev <= '0;
    end else begin
      ph_q    <= phase_i;
      ph_prev <= ph_q;
    end
  end

  onehot_enc4 u_enc (
    .onehot (ph_q),
    .idx    (enc_idx),
    .valid  (onehot)
  );

  always_comb begin
    legal     = onehot && (ph_q == ring_succ(ph_prev, ROT_LEFT));
    home      = (ph_q == HOME);
    rev_inc   = (state == LOCKED) && legal && home;
    lose_lock = (state == LOCKED) && !legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEARCH;
      run          <= '0;
      locked_o     <= 1'b0;
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
      rev_cnt_o    <= '0;
      rev_tick_o   <= 1'b0;
      idx_o        <= '0;
      idx_valid_o  <= 1'b0;
    end else begin
      locked_o <= 1'b0;
      err_o    <= 1'b0;
      unique case (state)
        SEARCH, FAULT: begin
          if (onehot) begin
            state <= LOCKING;
            run   <= '0;
          end else begin
            state <= SEARCH;
          end
        end
        LOCKING: begin
          if (legal) begin
            if (run == RUN_LAST) begin
              state    <= LOCKED;
              locked_o <= 1'b1;
            end else begin
              run <= run + 1'b1;
            end
          end else if (onehot) begin
            run <= '0;
          end else begin
            state <= SEARCH;
          end
        end
        LOCKED: begin
          if (legal) begin
            locked_o <= 1'b1;
          end else begin
            state <= FAULT;
            err_o <= 1'b1;
          end
        end
      endcase

      // A new error outranks a same-cycle clear.
      if (lose_lock)  err_sticky_o <= 1'b1;
      else if (clr_i) err_sticky_o <= 1'b0;

      // Clear outranks the increment, but the tick still reports it.
      rev_tick_o <= rev_inc;
      if (clr_i)        rev_cnt_o <= '0;
      else if (rev_inc) rev_cnt_o <= rev_cnt_o + REV_W'(1);

      idx_valid_o <= onehot;
      if (onehot) idx_o <= enc_idx;
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench: default-direction instance A and ROT_LEFT=1/REV_W=2 instance B.
module tb_ring_phase_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, clr_a, clr_b;
  logic [3:0] ph_a, ph_b;

  logic       locked_a, err_a, sticky_a, tick_a, ival_a;
  logic [7:0] cnt_a;
  logic [1:0] idx_a;
  logic       locked_b, err_b, sticky_b, tick_b, ival_b;
  logic [1:0] cnt_b;
  logic [1:0] idx_b;

  int tests_run    = 0;
  int tests_failed = 0;

  ring_phase_monitor #(.LOCK_CYCLES(4), .REV_W(8), .ROT_LEFT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_a), .phase_i(ph_a), .clr_i(clr_a),
    .locked_o(locked_a), .err_o(err_a), .err_sticky_o(sticky_a),
    .rev_cnt_o(cnt_a), .rev_tick_o(tick_a), .idx_o(idx_a), .idx_valid_o(ival_a)
  );

  ring_phase_monitor #(.LOCK_CYCLES(4), .REV_W(2), .ROT_LEFT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_b), .phase_i(ph_b), .clr_i(clr_b),
    .locked_o(locked_b), .err_o(err_b), .err_sticky_o(sticky_b),
    .rev_cnt_o(cnt_b), .rev_tick_o(tick_b), .idx_o(idx_b), .idx_valid_o(ival_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " locked"}, locked_a, 0);
    check({tag, " err"},    err_a,    0);
    check({tag, " sticky"}, sticky_a, 0);
    check({tag, " cnt"},    cnt_a,    0);
    check({tag, " tick"},   tick_a,   0);
    check({tag, " idx"},    idx_a,    0);
    check({tag, " ival"},   ival_a,   0);
  endtask

  task automatic reset_a();
    #3 rst_a = 1'b0;
    #1 check_a_zero("async_rst_a");
    tick();
    rst_a = 1'b1;
  endtask

  logic [3:0] seq_a [4];
  logic [3:0] seq_b [4];
  logic [3:0] seq_ill [9];
  logic [3:0] seq_zero [9];
  int         exp_cnt;
  bit         exp_tick;

  initial begin
    seq_a    = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    seq_b    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq_ill  = '{4'b1000, 4'b0100, 4'b0010, 4'b1000, 4'b0100,
                 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    seq_zero = '{4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b0001,
                 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    rst_a = 1'b0; rst_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    ph_a = '0; ph_b = '0;

    // Reset held with random input
    for (int i = 0; i < 3; i++) begin
      ph_a = 4'($urandom_range(15, 0));
      tick();
      check_a_zero($sformatf("rst_hold%0d", i));
    end
    rst_a = 1'b1;

    // Clean lock, edges 1..14
    for (int n = 1; n <= 14; n++) begin
      ph_a = seq_a[(n - 1) % 4];
      tick();
      check($sformatf("lock_a e%0d", n), locked_a, (n >= 6) ? 1 : 0);
      check($sformatf("tick_a e%0d", n), tick_a, (n == 10 || n == 14) ? 1 : 0);
      check($sformatf("cnt_a e%0d", n), cnt_a, (n >= 14) ? 2 : (n >= 10) ? 1 : 0);
      check($sformatf("err_a e%0d", n), err_a, 0);
      if (n >= 2) begin
        check($sformatf("idx_a e%0d", n), idx_a, 3 - ((n - 2) % 4));
        check($sformatf("ival_a e%0d", n), ival_a, 1);
      end else begin
        check("idx_a e1", idx_a, 0);
        check("ival_a e1", ival_a, 0);
      end
    end

    // Fault while locked: 0110 captured at edge 15
    ph_a = 4'b0110; tick();
    check("flt e15 locked", locked_a, 1);
    check("flt e15 err", err_a, 0);
    ph_a = 4'b0001; tick();
    check("flt e16 err", err_a, 1);
    check("flt e16 sticky", sticky_a, 1);
    check("flt e16 locked", locked_a, 0);
    check("flt e16 ival", ival_a, 0);
    ph_a = 4'b1000; tick();
    check("flt e17 err", err_a, 0);
    check("flt e17 sticky", sticky_a, 1);
    ph_a = 4'b0100; tick();
    ph_a = 4'b0010; tick();
    ph_a = 4'b0001; tick();
    check("relock e20 locked", locked_a, 0);
    ph_a = 4'b1000; tick();
    check("relock e21 locked", locked_a, 1);
    ph_a = 4'b0100; tick();
    check("relock e22 tick", tick_a, 1);
    check("relock e22 cnt", cnt_a, 3);
    check("relock e22 err", err_a, 0);
    ph_a = 4'b0010; clr_a = 1'b1; tick();
    clr_a = 1'b0;
    check("clr_a sticky", sticky_a, 0);
    check("clr_a cnt", cnt_a, 0);
    check("clr_a locked", locked_a, 1);

    // Illegal order during locking resets the run without error
    reset_a();
    for (int k = 1; k <= 9; k++) begin
      ph_a = seq_ill[k - 1];
      tick();
      check($sformatf("ill lock e%0d", k), locked_a, (k >= 9) ? 1 : 0);
      check($sformatf("ill err e%0d", k), err_a, 0);
      check($sformatf("ill sticky e%0d", k), sticky_a, 0);
    end

    // All-zero sample during locking drops back to search
    reset_a();
    for (int k = 1; k <= 9; k++) begin
      ph_a = seq_zero[k - 1];
      tick();
      check($sformatf("zero lock e%0d", k), locked_a, (k >= 9) ? 1 : 0);
      check($sformatf("zero err e%0d", k), err_a, 0);
      if (k == 4) begin
        check("zero e4 ival", ival_a, 0);
        check("zero e4 idx hold", idx_a, 2);
      end
      if (k == 5) begin
        check("zero e5 ival", ival_a, 1);
        check("zero e5 idx", idx_a, 1);
      end
    end
    rst_a = 1'b0;

    // ROT_LEFT=1, REV_W=2: wrap and clear/increment collision at edge 26
    rst_b = 1'b1;
    exp_cnt = 0;
    for (int n = 1; n <= 26; n++) begin
      ph_b  = seq_b[(n - 1) % 4];
      clr_b = (n == 26);
      tick();
      clr_b = 1'b0;
      exp_tick = (n >= 10) && ((n - 10) % 4 == 0);
      if (exp_tick) exp_cnt = (n == 26) ? 0 : (exp_cnt + 1) % 4;
      check($sformatf("lock_b e%0d", n), locked_b, (n >= 6) ? 1 : 0);
      check($sformatf("tick_b e%0d", n), tick_b, exp_tick);
      check($sformatf("cnt_b e%0d", n), cnt_b, exp_cnt);
      check($sformatf("err_b e%0d", n), err_b, 0);
      if (n >= 2) check($sformatf("idx_b e%0d", n), idx_b, (n - 2) % 4);
    end
    check("wrap cnt_b final", cnt_b, 0);

    // Asynchronous reset mid-stream
    #3 rst_b = 1'b0;
    #1;
    check("async_b locked", locked_b, 0);
    check("async_b cnt", cnt_b, 0);
    check("async_b tick", tick_b, 0);
    check("async_b idx", idx_b, 0);
    check("async_b ival", ival_b, 0);
    check("async_b sticky", sticky_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
